// File: rtl/fpu_addsub_seq.sv
// Multi-cycle add/subtract for the sign/exponent/mantissa word format.
// Operands are swapped, aligned, summed, normalised and rounded (RNE) over several cycles.
module fpu_addsub_seq #(
  parameter int unsigned EXP_W  = 6,
  parameter int unsigned MANT_W = 25,
  localparam int unsigned W     = 1 + EXP_W + MANT_W
) (
  input  logic         clock100KHz,
  input  logic         reset,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] op_A_in,
  input  logic [W-1:0] op_B_in,
  input  logic         clear_flags,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out,
  output logic         flags_out
);

  // Internal mantissa layout: carry, hidden, mantissa, guard, round, sticky.
  localparam int unsigned M        = MANT_W + 5;
  localparam int unsigned AlignMax = MANT_W + 2;
  localparam logic [EXP_W-1:0] ExpMax = '1;

  typedef enum logic [2:0] {
    StIdle, StLoad, StAlign, StAdd, StNorm, StRound, StDone
  } state_e;

  state_e           r_state, w_state_nx;
  logic [W-1:0]     r_op_a, w_op_a_nx;
  logic [W-1:0]     r_op_b, w_op_b_nx;
  logic             r_sub, w_sub_nx;
  logic             r_sign_l, w_sign_l_nx;
  logic             r_sign_s, w_sign_s_nx;
  logic [EXP_W:0]   r_exp, w_exp_nx;
  logic [M-1:0]     r_m_l, w_m_l_nx;
  logic [M-1:0]     r_m_s, w_m_s_nx;
  logic [EXP_W-1:0] r_d, w_d_nx;
  logic             r_nbase, w_nbase_nx;
  logic             r_zero, w_zero_nx;
  logic             r_unf, w_unf_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic [W-1:0]     r_data, w_data_nx;
  logic [3:0]       r_status, w_status_nx;
  logic             r_flags, w_flags_nx;
  logic             w_set_flag;

  // Operand decode, valid while in LOAD.
  logic [EXP_W-1:0]  w_exp_a, w_exp_b, w_d;
  logic [MANT_W-1:0] w_man_a, w_man_b;
  logic              w_zero_a, w_zero_b, w_inf_a, w_inf_b;
  logic              w_sign_a, w_sign_b, w_a_ge_b, w_inf_sign;
  logic [M-1:0]      w_sig_a, w_sig_b;

  assign w_exp_a  = r_op_a[W-2:MANT_W];
  assign w_exp_b  = r_op_b[W-2:MANT_W];
  assign w_zero_a = (w_exp_a == '0);
  assign w_zero_b = (w_exp_b == '0);
  assign w_inf_a  = &w_exp_a;
  assign w_inf_b  = &w_exp_b;
  assign w_man_a  = w_zero_a ? '0 : r_op_a[MANT_W-1:0];
  assign w_man_b  = w_zero_b ? '0 : r_op_b[MANT_W-1:0];
  assign w_sign_a = r_op_a[W-1];
  assign w_sign_b = r_op_b[W-1] ^ r_sub;
  assign w_sig_a  = {1'b0, ~w_zero_a, w_man_a, 3'b000};
  assign w_sig_b  = {1'b0, ~w_zero_b, w_man_b, 3'b000};
  assign w_a_ge_b = ({w_exp_a, w_man_a} >= {w_exp_b, w_man_b});
  assign w_d      = w_a_ge_b ? (w_exp_a - w_exp_b) : (w_exp_b - w_exp_a);
  // inf - inf with opposing effective signs resolves to +inf.
  assign w_inf_sign = (w_inf_a & w_inf_b) ? ((w_sign_a == w_sign_b) ? w_sign_a : 1'b0)
                    : (w_inf_a ? w_sign_a : w_sign_b);

  // Shifters and adder.
  logic [M-1:0] w_s_shr, w_l_shr, w_l_shl, w_sum;

  assign w_s_shr = {1'b0, r_m_s[M-1:2], |r_m_s[1:0]};
  assign w_l_shr = {1'b0, r_m_l[M-1:2], |r_m_l[1:0]};
  assign w_l_shl = {r_m_l[M-2:0], 1'b0};
  assign w_sum   = (r_sign_l == r_sign_s) ? (r_m_l + r_m_s) : (r_m_l - r_m_s);

  // Round to nearest even on guard/round/sticky.
  logic              w_inexact, w_up, w_ovf;
  logic [MANT_W+1:0] w_rsig;
  logic [EXP_W:0]    w_rexp;
  logic [MANT_W-1:0] w_rmant;

  assign w_inexact = |r_m_l[2:0];
  assign w_up      = r_m_l[2] & (r_m_l[1] | r_m_l[0] | r_m_l[3]);
  assign w_rsig    = {1'b0, r_m_l[M-2:3]} + {{(MANT_W+1){1'b0}}, w_up};
  assign w_rexp    = r_exp + {{EXP_W{1'b0}}, w_rsig[MANT_W+1]};
  assign w_rmant   = w_rsig[MANT_W+1] ? w_rsig[MANT_W:1] : w_rsig[MANT_W-1:0];
  assign w_ovf     = (w_rexp >= {1'b0, ExpMax});

  always_comb begin
    w_state_nx  = r_state;
    w_op_a_nx   = r_op_a;
    w_op_b_nx   = r_op_b;
    w_sub_nx    = r_sub;
    w_sign_l_nx = r_sign_l;
    w_sign_s_nx = r_sign_s;
    w_exp_nx    = r_exp;
    w_m_l_nx    = r_m_l;
    w_m_s_nx    = r_m_s;
    w_d_nx      = r_d;
    w_nbase_nx  = r_nbase;
    w_zero_nx   = r_zero;
    w_unf_nx    = r_unf;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    w_data_nx   = r_data;
    w_status_nx = r_status;
    w_set_flag  = 1'b0;

    case (r_state)
      StIdle: begin
        if (start) begin
          w_op_a_nx  = op_A_in;
          w_op_b_nx  = op_B_in;
          w_sub_nx   = op_sub;
          w_busy_nx  = 1'b1;
          w_state_nx = StLoad;
        end
      end
      StLoad: begin
        w_nbase_nx = 1'b1;
        w_zero_nx  = 1'b0;
        w_unf_nx   = 1'b0;
        if (w_inf_a || w_inf_b) begin
          w_data_nx   = {w_inf_sign, ExpMax, {MANT_W{1'b0}}};
          w_status_nx = 4'b0100;
          w_set_flag  = 1'b1;
          w_busy_nx   = 1'b0;
          w_done_nx   = 1'b1;
          w_state_nx  = StDone;
        end else begin
          w_sign_l_nx = w_a_ge_b ? w_sign_a : w_sign_b;
          w_sign_s_nx = w_a_ge_b ? w_sign_b : w_sign_a;
          w_m_l_nx    = w_a_ge_b ? w_sig_a : w_sig_b;
          w_m_s_nx    = w_a_ge_b ? w_sig_b : w_sig_a;
          w_exp_nx    = {1'b0, (w_a_ge_b ? w_exp_a : w_exp_b)};
          w_d_nx      = w_d;
          w_state_nx  = (w_d == '0) ? StAdd : StAlign;
        end
      end
      StAlign: begin
        if (32'(r_d) > AlignMax) begin
          w_m_s_nx   = {{(M-1){1'b0}}, |r_m_s};
          w_state_nx = StAdd;
        end else begin
          w_m_s_nx = w_s_shr;
          w_d_nx   = r_d - {{(EXP_W-1){1'b0}}, 1'b1};
          if (r_d == {{(EXP_W-1){1'b0}}, 1'b1}) begin
            w_state_nx = StAdd;
          end
        end
      end
      StAdd: begin
        w_m_l_nx   = w_sum;
        w_state_nx = StNorm;
      end
      StNorm: begin
        if (r_nbase) begin
          w_nbase_nx = 1'b0;
          if (r_m_l[M-1]) begin
            w_m_l_nx   = w_l_shr;
            w_exp_nx   = r_exp + {{EXP_W{1'b0}}, 1'b1};
            w_state_nx = StRound;
          end else if (r_m_l == '0) begin
            w_zero_nx  = 1'b1;
            w_state_nx = StRound;
          end else if (r_m_l[M-2]) begin
            w_state_nx = StRound;
          end
        end else if (r_exp == {{EXP_W{1'b0}}, 1'b1}) begin
          // One more left shift would push the exponent to the zero encoding.
          w_unf_nx   = 1'b1;
          w_state_nx = StRound;
        end else begin
          w_m_l_nx = w_l_shl;
          w_exp_nx = r_exp - {{EXP_W{1'b0}}, 1'b1};
          if (r_m_l[M-3]) begin
            w_state_nx = StRound;
          end
        end
      end
      StRound: begin
        if (r_zero) begin
          w_data_nx   = '0;
          w_status_nx = 4'b0001;
        end else if (r_unf) begin
          w_data_nx   = {r_sign_l, {(W-1){1'b0}}};
          w_status_nx = 4'b1000;
        end else if (w_ovf) begin
          w_data_nx   = {r_sign_l, ExpMax, {MANT_W{1'b0}}};
          w_status_nx = 4'b0100;
        end else begin
          w_data_nx   = {r_sign_l, w_rexp[EXP_W-1:0], w_rmant};
          w_status_nx = w_inexact ? 4'b0010 : 4'b0001;
        end
        w_set_flag = (w_status_nx != 4'b0001);
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b1;
        w_state_nx = StDone;
      end
      StDone: begin
        w_state_nx = StIdle;
      end
      default: begin
        w_state_nx = StIdle;
      end
    endcase

    // A setting done wins over a simultaneous clear.
    w_flags_nx = (r_flags & ~clear_flags) | w_set_flag;
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_sub    <= 1'b0;
      r_sign_l <= 1'b0;
      r_sign_s <= 1'b0;
      r_exp    <= '0;
      r_m_l    <= '0;
      r_m_s    <= '0;
      r_d      <= '0;
      r_nbase  <= 1'b0;
      r_zero   <= 1'b0;
      r_unf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_data   <= '0;
      r_status <= 4'b0001;
      r_flags  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_op_a   <= w_op_a_nx;
      r_op_b   <= w_op_b_nx;
      r_sub    <= w_sub_nx;
      r_sign_l <= w_sign_l_nx;
      r_sign_s <= w_sign_s_nx;
      r_exp    <= w_exp_nx;
      r_m_l    <= w_m_l_nx;
      r_m_s    <= w_m_s_nx;
      r_d      <= w_d_nx;
      r_nbase  <= w_nbase_nx;
      r_zero   <= w_zero_nx;
      r_unf    <= w_unf_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
      r_data   <= w_data_nx;
      r_status <= w_status_nx;
      r_flags  <= w_flags_nx;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign data_out   = r_data;
  assign status_out = r_status;
  assign flags_out  = r_flags;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Bench for fpu_addsub_seq: directed scenarios plus random operands against an
// exact-arithmetic round-to-nearest-even reference.
module tb_fpu_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op_sub;
  logic        clear_flags;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic        flags_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fpu_addsub_seq dut (
    .clock100KHz(clk),
    .reset      (rst_n),
    .start      (start),
    .op_sub     (op_sub),
    .op_A_in    (a_in),
    .op_B_in    (b_in),
    .clear_flags(clear_flags),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .status_out (status_out),
    .flags_out  (flags_out)
  );

  // Exact reference: place both significands on a common integer grid, add, then round.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                output logic [31:0] res, output logic [3:0] st);
    logic         sa, sb, sr, up;
    int           ea, eb, p, sh, er;
    logic [127:0] ma, mb, mag, q, rem, half;
    sa = a[31];
    sb = b[31] ^ sub;
    ea = int'(a[30:25]);
    eb = int'(b[30:25]);
    ma = (ea == 0) ? 128'd0 : ({102'd0, 1'b1, a[24:0]} << (ea - 1));
    mb = (eb == 0) ? 128'd0 : ({102'd0, 1'b1, b[24:0]} << (eb - 1));
    if (sa == sb) begin
      mag = ma + mb; sr = sa;
    end else if (ma >= mb) begin
      mag = ma - mb; sr = sa;
    end else begin
      mag = mb - ma; sr = sb;
    end
    if (mag == 128'd0) begin
      res = 32'd0; st = 4'b0001;
      return;
    end
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    er = p - 24;
    if (er < 1) begin
      res = {sr, 31'd0}; st = 4'b1000;
      return;
    end
    sh = p - 25;
    q = mag >> sh;
    if (sh > 0) begin
      rem  = mag & ((128'd1 << sh) - 128'd1);
      half = 128'd1 << (sh - 1);
    end else begin
      rem = 128'd0; half = 128'd0;
    end
    up = (rem > half) || ((rem == half) && (rem != 128'd0) && q[0]);
    q = q + {127'd0, up};
    if (q[26]) begin
      q = q >> 1; er++;
    end
    if (er >= 63) begin
      res = {sr, 6'h3f, 25'd0}; st = 4'b0100;
    end else begin
      res = {sr, 6'(er), q[24:0]};
      st  = (rem != 128'd0) ? 4'b0010 : 4'b0001;
    end
  endfunction

  // Issue one operation; lat is the edge count after capture at which done was seen (-1 if never).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output logic [31:0] res, output logic [3:0] st, output int lat);
    if (done) begin
      @(posedge clk); #1;
    end
    a_in = a; b_in = b; op_sub = sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    res = data_out;
    st  = status_out;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, done, flags_out} !== 3'b000) begin
      n_errors++; $display("FAIL reset_ctrl busy/done/flags=%b want 000", {busy, done, flags_out});
    end
    n_checks++;
    if (data_out !== 32'd0) begin
      n_errors++; $display("FAIL reset_data got %h want 00000000", data_out);
    end
    n_checks++;
    if (status_out !== 4'b0001) begin
      n_errors++; $display("FAIL reset_status got %b want 0001", status_out);
    end
  endtask

  task automatic test_add_basic();
    logic [31:0] r; logic [3:0] s; int l;
    run_op(32'h3E000000, 32'h3E000000, 1'b0, r, s, l);
    n_checks++;
    if (r !== 32'h40000000) begin n_errors++; $display("FAIL add_data got %h want 40000000", r); end
    n_checks++;
    if (s !== 4'b0001) begin n_errors++; $display("FAIL add_status got %b want 0001", s); end
    n_checks++;
    if (l !== 4) begin n_errors++; $display("FAIL add_latency got %0d want 4", l); end
    n_checks++;
    if (flags_out !== 1'b0) begin n_errors++; $display("FAIL add_flags got %b want 0", flags_out); end
  endtask

  task automatic test_sub_exact();
    logic [31:0] r; logic [3:0] s; int l;
    run_op(32'h3E000000, 32'h3E000000, 1'b1, r, s, l);
    n_checks++;
    if (r !== 32'h00000000) begin n_errors++; $display("FAIL sub_data got %h want 00000000", r); end
    n_checks++;
    if (s !== 4'b0001) begin n_errors++; $display("FAIL sub_status got %b want 0001", s); end
    n_checks++;
    if (l !== 4) begin n_errors++; $display("FAIL sub_latency got %0d want 4", l); end
  endtask

  task automatic test_sticky_align();
    logic [31:0] r; logic [3:0] s; int l;
    run_op(32'h3E000000, 32'h02000000, 1'b0, r, s, l);
    n_checks++;
    if (r !== 32'h3E000000) begin n_errors++; $display("FAIL sticky_data got %h want 3E000000", r); end
    n_checks++;
    if (s !== 4'b0010) begin n_errors++; $display("FAIL sticky_status got %b want 0010", s); end
    n_checks++;
    if (l !== 5) begin n_errors++; $display("FAIL sticky_latency got %0d want 5", l); end
    n_checks++;
    if (flags_out !== 1'b1) begin n_errors++; $display("FAIL sticky_flags got %b want 1", flags_out); end
  endtask

  task automatic test_overflow_clear();
    logic [31:0] r; logic [3:0] s; int l;
    run_op(32'h7C000000, 32'h7C000000, 1'b0, r, s, l);
    n_checks++;
    if (r !== 32'h7E000000) begin n_errors++; $display("FAIL ovf_data got %h want 7E000000", r); end
    n_checks++;
    if (s !== 4'b0100) begin n_errors++; $display("FAIL ovf_status got %b want 0100", s); end
    n_checks++;
    if (l !== 4) begin n_errors++; $display("FAIL ovf_latency got %0d want 4", l); end
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    n_checks++;
    if (flags_out !== 1'b0) begin n_errors++; $display("FAIL clear_flags got %b want 0", flags_out); end
  endtask

  task automatic test_underflow();
    logic [31:0] r; logic [3:0] s; int l;
    run_op(32'h02000001, 32'h02000000, 1'b1, r, s, l);
    n_checks++;
    if (r !== 32'h00000000) begin n_errors++; $display("FAIL unf_data got %h want 00000000", r); end
    n_checks++;
    if (s !== 4'b1000) begin n_errors++; $display("FAIL unf_status got %b want 1000", s); end
    n_checks++;
    if (flags_out !== 1'b1) begin n_errors++; $display("FAIL unf_flags got %b want 1", flags_out); end
  endtask

  task automatic test_infinity();
    logic [31:0] r; logic [3:0] s; int l;
    run_op(32'h7E000000, 32'h3E000000, 1'b0, r, s, l);
    n_checks++;
    if (r !== 32'h7E000000) begin n_errors++; $display("FAIL inf_add_data got %h want 7E000000", r); end
    n_checks++;
    if (s !== 4'b0100) begin n_errors++; $display("FAIL inf_add_status got %b want 0100", s); end
    run_op(32'h3E000000, 32'h7E000000, 1'b1, r, s, l);
    n_checks++;
    if (r !== 32'hFE000000) begin n_errors++; $display("FAIL inf_sub_data got %h want FE000000", r); end
    n_checks++;
    if (l < 0) begin n_errors++; $display("FAIL inf_sub_timeout got %0d want done", l); end
  endtask

  task automatic test_abort_and_busy();
    int lat;
    if (done) begin
      @(posedge clk); #1;
    end
    a_in = 32'h3E000000; b_in = 32'h3E000000; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL abort_busy got %b want 1", busy); end
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0) begin n_errors++; $display("FAIL abort_done_early got %b want 0", done); end
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, flags_out, status_out} !== 7'b000_0001 || data_out !== 32'd0) begin
      n_errors++;
      $display("FAIL abort_reset b/d/f/st=%b data=%h want 0000001 00000000",
               {busy, done, flags_out, status_out}, data_out);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0) begin n_errors++; $display("FAIL abort_done_in_reset got %b want 0", done); end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_in = 32'h3E000000; b_in = 32'h3E000000; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    // Keep requesting different work while busy; it must be ignored.
    a_in = 32'h7C000000; b_in = 32'h7C000000; op_sub = 1'b1;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i == 2) start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    n_checks++;
    if (lat !== 4) begin n_errors++; $display("FAIL rerun_latency got %0d want 4", lat); end
    n_checks++;
    if (data_out !== 32'h40000000) begin
      n_errors++; $display("FAIL rerun_data got %h want 40000000", data_out);
    end
    n_checks++;
    if (status_out !== 4'b0001) begin
      n_errors++; $display("FAIL rerun_status got %b want 0001", status_out);
    end
  endtask

  task automatic test_clear_vs_set();
    logic [31:0] r; logic [3:0] s; int l;
    clear_flags = 1'b1;
    @(posedge clk); #1;
    run_op(32'h3E000000, 32'h02000000, 1'b0, r, s, l);
    n_checks++;
    if (flags_out !== 1'b1) begin
      n_errors++; $display("FAIL clear_vs_set got %b want 1", flags_out);
    end
    clear_flags = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, exp_r;
    logic [3:0]  s, exp_s;
    logic        sub, exp_flags;
    int          l, ea, eb, mode;
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    exp_flags = 1'b0;
    for (int n = 0; n < 120; n++) begin
      mode = int'($urandom_range(0, 3));
      ea   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 62));
      a    = {1'($urandom), 6'(ea), 25'($urandom)};
      case (mode)
        0: eb = int'($urandom_range(0, 62));
        1: eb = ea + int'($urandom_range(0, 4)) - 2;
        2: eb = ea;
        default: eb = ea - int'($urandom_range(20, 32));
      endcase
      if (eb < 0) eb = 0;
      if (eb > 62) eb = 62;
      b = {1'($urandom), 6'(eb), 25'($urandom)};
      if (mode == 2) b[24:0] = a[24:0] ^ 25'($urandom_range(0, 7));
      sub = 1'($urandom);
      model(a, b, sub, exp_r, exp_s);
      exp_flags = exp_flags | (exp_s != 4'b0001);
      run_op(a, b, sub, r, s, l);
      n_checks++;
      if (l < 0) begin
        n_errors++; $display("FAIL rnd_timeout a=%h b=%h sub=%b got no done want done", a, b, sub);
      end
      n_checks++;
      if (r !== exp_r || s !== exp_s) begin
        n_errors++;
        $display("FAIL rnd_result a=%h b=%h sub=%b got %h/%b want %h/%b",
                 a, b, sub, r, s, exp_r, exp_s);
      end
      n_checks++;
      if (flags_out !== exp_flags) begin
        n_errors++; $display("FAIL rnd_flags got %b want %b", flags_out, exp_flags);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; clear_flags = 1'b0;
    a_in = 32'd0; b_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add_basic();
    test_sub_exact();
    test_sticky_align();
    test_overflow_clear();
    test_underflow();
    test_infinity();
    test_abort_and_busy();
    test_clear_vs_set();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
